jtcop_objdma: RTL

JTCOP_OBJDMA -- requirements
Module: jtcop_objdma

---
 rtl/jtcop_objdma.sv | 117 +++++++++++
 1 files changed

// File: rtl/jtcop_objdma.sv
// jtcop_objdma: copies LEN 16-bit object words from CPU-side RAM into the
// display-side buffer, one word per clock, optionally deferred to vertical blank.
module jtcop_objdma #(
   parameter int LEN     = 1024,
   parameter bit WAIT_VB = 1'b1
) (
   input  logic        rst,
   input  logic        clk,
   input  logic        obj_copy,
   input  logic        LVBL,
   output logic [9:0]  src_addr,
   input  logic [15:0] src_data,
   output logic [9:0]  dst_addr,
   output logic [15:0] dst_data,
   output logic        dst_we,
   output logic        busy,
   output logic        done
);

   // state | meaning
   // IDLE  | waiting for an obj_copy rising edge
   // PEND  | request accepted, waiting for LVBL low (blanking)
   // COPY  | issuing reads 0..LEN-1; from the second cycle on, writing the previous word
   // FLUSH | writing the final word LEN-1
   typedef enum logic [1:0] {IDLE, PEND, COPY, FLUSH} state_t;

   localparam int            AW    = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [AW-1:0] LAST  = AW'(LEN - 1);
   localparam state_t        START = WAIT_VB ? PEND : COPY;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          done_q, done_d;
   logic          copy_q;
   logic [9:0]    hold_addr_q;
   logic [15:0]   hold_data_q;
   logic          copy_edge;
   logic          we;
   logic [AW-1:0] wr_addr;

   // copy_q resets to 0 so a request held high through reset still counts as an edge
   assign copy_edge = obj_copy & ~copy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         done_q      <= 1'b0;
         copy_q      <= 1'b0;
         hold_addr_q <= '0;
         hold_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         copy_q  <= obj_copy;
         if (we) begin
            hold_addr_q <= 10'(wr_addr);
            hold_data_q <= src_data;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      done_d  = 1'b0;
      we      = 1'b0;
      wr_addr = cnt_q;
      case (state_q)
         IDLE: begin
            if (copy_edge) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         PEND: begin
            cnt_d = '0;
            if (!LVBL) state_d = COPY;
         end
         COPY: begin
            if (cnt_q != '0) begin
               we      = 1'b1;
               wr_addr = cnt_q - AW'(1);
            end
            if (copy_edge) pend_d = 1'b1;
            if (cnt_q == LAST) state_d = FLUSH;
            else cnt_d = cnt_q + AW'(1);
         end
         FLUSH: begin
            we     = 1'b1;
            done_d = 1'b1;
            // a request arriving during the final write is chained like any other
            if (pend_q || copy_edge) begin
               state_d = START;
               pend_d  = 1'b0;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign src_addr = 10'(cnt_q);
   assign dst_we   = we;
   assign dst_addr = we ? 10'(wr_addr) : hold_addr_q;
   assign dst_data = we ? src_data : hold_data_q;
   assign busy     = (state_q == COPY) || (state_q == FLUSH);
   assign done     = done_q;

endmodule
